// File: rtl/op_result_encoder_pkg.sv
// Shared definitions for the operation-unit return path (4-to-2 encoder).
// Holds the fixed requester count, the code width, the presenter FSM state
// type and the code values shared with the forward 2-4 decoder.
package op_result_encoder_pkg;

    // Requester count is tied to the 2-bit code; other values are unsupported.
    localparam int NREQ = 4;
    localparam int CW   = 2;

    // Code values, identical to the forward decoder's input encoding.
    localparam logic [CW-1:0] OP0 = 2'd0;
    localparam logic [CW-1:0] OP1 = 2'd1;
    localparam logic [CW-1:0] OP2 = 2'd2;
    localparam logic [CW-1:0] OP3 = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/op_result_encoder_rr.sv
// rr_prio_enc_4: combinational round-robin priority encoder.
// Picks the first set request bit searching upward from the pointer,
// wrapping modulo 4.
// Ports:
//   i_req  [3:0]  request vector
//   i_ptr  [1:0]  search start position
//   o_idx  [1:0]  index of the winning request (0 when none)
//   o_any         at least one request is set
module rr_prio_enc_4
    import op_result_encoder_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [CW-1:0]   i_ptr,
    output logic [CW-1:0]   o_idx,
    output logic            o_any
);

    logic [CW-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // 2-bit add wraps naturally, giving the modulo-4 search order.
            w_cand = i_ptr + CW'(k);
            if (!o_any && i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/op_result_encoder.sv
// op_result_encoder: return path from the four operation units.
// Buffers one result per unit, picks a pending unit round-robin and presents
// its 2-bit code plus result over a VALID/READY handshake.
// Ports:
//   CLK, RST_N        clock (rising edge), async active-low reset
//   ENABLE            capture enable; pending/in-flight data drains regardless
//   REQ[3:0]          per-unit completion request
//   RES0..RES3        per-unit results
//   VALID/READY       downstream handshake
//   CODE[1:0], DATA   winning unit index and its result
//   PEND[3:0]         pending-slot bitmap
//   OVF[3:0]          sticky overflow flags, CLR_OVF clears them
module op_result_encoder #(
    parameter int DW   = 8,
    parameter int NREQ = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ENABLE,
    input  logic [3:0]    REQ,
    input  logic [DW-1:0] RES0,
    input  logic [DW-1:0] RES1,
    input  logic [DW-1:0] RES2,
    input  logic [DW-1:0] RES3,
    output logic          VALID,
    input  logic          READY,
    output logic [1:0]    CODE,
    output logic [DW-1:0] DATA,
    output logic [3:0]    PEND,
    output logic [3:0]    OVF,
    input  logic          CLR_OVF
);

    import op_result_encoder_pkg::*;

    state_t        r_state;
    logic          r_valid;
    logic [CW-1:0] r_code;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_ptr;
    logic [3:0]    r_pend;
    logic [3:0]    r_ovf;
    logic [DW-1:0] r_hold [4];

    logic [DW-1:0] w_res [4];
    logic          w_accept;
    logic [3:0]    w_acc_vec;
    logic [3:0]    w_pend_eff;
    logic [3:0]    w_cap;
    logic [3:0]    w_ovf_set;
    logic [CW-1:0] w_sel;
    logic          w_any;

    assign w_res[0] = RES0;
    assign w_res[1] = RES1;
    assign w_res[2] = RES2;
    assign w_res[3] = RES3;

    assign w_accept = r_valid && READY;

    // The slot being accepted this edge counts as free, so a same-cycle
    // re-request is captured rather than flagged as overflow.
    always_comb begin
        w_acc_vec = '0;
        if (w_accept) begin
            w_acc_vec[r_code] = 1'b1;
        end
        w_pend_eff = r_pend & ~w_acc_vec;
        w_cap      = {4{ENABLE}} & REQ & ~w_pend_eff;
        w_ovf_set  = {4{ENABLE}} & REQ &  w_pend_eff;
    end

    // Selection uses registered PEND only: requests captured on the same
    // edge become eligible one cycle later.
    rr_prio_enc_4 u_rr (
        .i_req (r_pend),
        .i_ptr (r_ptr),
        .o_idx (w_sel),
        .o_any (w_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_code  <= OP0;
            r_data  <= '0;
            r_ptr   <= '0;
            r_pend  <= '0;
            r_ovf   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_eff | w_cap;
            // Set beats clear when both happen on the same edge.
            r_ovf  <= (CLR_OVF ? 4'b0000 : r_ovf) | w_ovf_set;
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_cap[i]) begin
                    r_hold[i] <= w_res[i];
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_code  <= w_sel;
                        r_data  <= r_hold[w_sel];
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (READY) begin
                        r_valid <= 1'b0;
                        r_ptr   <= r_code + 2'd1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign VALID = r_valid;
    assign CODE  = r_code;
    assign DATA  = r_data;
    assign PEND  = r_pend;
    assign OVF   = r_ovf;

endmodule
